// File: rtl/fpu_ctx_seq_if.sv
// Handshake and register-file bundle for the FPU context sequencer.
// master = sequencer side, slave = register file / stream / control side.
interface fpu_ctx_seq_if;
    logic        save_start;
    logic        restore_start;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_we;
    logic [3:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    modport master (
        input  save_start, restore_start, rf_rd,
        input  out_ready, in_valid, in_data, in_last,
        output busy, done, err, rf_ra, rf_we, rf_a3, rf_wd,
        output out_valid, out_data, out_last, in_ready
    );

    modport slave (
        output save_start, restore_start, rf_rd,
        output out_ready, in_valid, in_data, in_last,
        input  busy, done, err, rf_ra, rf_we, rf_a3, rf_wd,
        input  out_valid, out_data, out_last, in_ready
    );
endinterface

// File: rtl/fpu_ctx_seq.sv
// FPU context save/restore sequencer: streams registers 0..NREGS-1 out
// on save and writes a framed stream back on restore.
module fpu_ctx_seq #(
    parameter int NREGS = 15
) (
    input  logic          clk,
    input  logic          reset,
    fpu_ctx_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    localparam logic [3:0] LAST = 4'(NREGS - 1);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic       err_q, err_d;
    logic       at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign at_last = (idx_q == LAST);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        err_d         = err_q;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.in_ready  = 1'b0;
        bus.rf_we     = 1'b0;
        bus.done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.save_start) begin
                    state_d = SAVE;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end else if (bus.restore_start) begin
                    state_d = RESTORE;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SAVE: begin
                bus.out_valid = 1'b1;
                bus.out_last  = at_last;
                if (bus.out_ready) begin
                    if (at_last) state_d = DONE;
                    else         idx_d   = idx_q + 4'd1;
                end
            end
            RESTORE: begin
                bus.in_ready = 1'b1;
                bus.rf_we    = bus.in_valid;
                if (bus.in_valid) begin
                    // Framing is good only when in_last lands on the final index.
                    if (at_last || bus.in_last) begin
                        state_d = DONE;
                        err_d   = !(at_last && bus.in_last);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.err      = err_q;
    assign bus.rf_ra    = idx_q;
    assign bus.rf_a3    = idx_q;
    assign bus.out_data = bus.rf_rd;
    assign bus.rf_wd    = bus.in_data;
endmodule
